// File: rtl/data_memory_bytelane.sv
// MEM-stage data memory with little-endian byte/half/word access, error flags,
// a read-only debug port, and a post-reset clear sequencer that holds off accesses.
module data_memory_bytelane #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    i_address,
    input  logic [31:0]              i_write_data,
    input  logic                     i_MemRead,
    input  logic                     i_MemWrite,
    input  logic [1:0]               i_size,
    input  logic                     i_unsigned,
    input  logic [$clog2(DEPTH)-1:0] i_dbg_address,
    output logic [31:0]              o_read_data,
    output logic [31:0]              o_dbg_data,
    output logic                     o_ready,
    output logic                     o_misaligned,
    output logic                     o_addr_error
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {INIT, READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [31:0]   dbg_data_q;
    logic          mis_q, mis_d;
    logic          aerr_q, aerr_d;

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          addr_err;
    logic          misaligned;
    logic          access;
    logic          access_ok;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdata;
    logic [31:0]   rd_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;

    assign word_idx = i_address[AW+1:2];
    assign lane     = i_address[1:0];

    // Addresses that fit exactly in the array have no bits left over to flag.
    if (ADDR_WIDTH > AW + 2) begin : g_addr_hi
        assign addr_err = |i_address[ADDR_WIDTH-1:AW+2];
    end else begin : g_addr_fit
        assign addr_err = 1'b0;
    end

    always_comb begin
        misaligned = 1'b0;
        case (i_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = |lane;
            default: misaligned = 1'b1;
        endcase
    end

    assign access    = (state_q == READY) && (i_MemRead || i_MemWrite);
    assign access_ok = access && !addr_err && !misaligned;

    // Store data is replicated across lanes so the byte-enable alone picks the target.
    always_comb begin
        st_be   = 4'b1111;
        st_data = i_write_data;
        case (i_size)
            2'b00: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{i_write_data[7:0]}};
            end
            2'b01: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{i_write_data[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = i_write_data;
            end
        endcase
    end

    always_comb begin
        mem_we    = 4'b0000;
        mem_idx   = word_idx;
        mem_wdata = st_data;
        if (state_q == INIT) begin
            mem_we    = INIT_CLEAR ? 4'b1111 : 4'b0000;
            mem_idx   = clr_idx_q;
            mem_wdata = '0;
        end else if (access_ok && i_MemWrite) begin
            mem_we = st_be;
        end
    end

    // NOTE: the array has no reset; clearing it is the sequencer's job, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) begin
                mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign rd_word = mem_q[word_idx];

    always_comb begin
        byte_sel = rd_word[7:0];
        case (lane)
            2'b00:   byte_sel = rd_word[7:0];
            2'b01:   byte_sel = rd_word[15:8];
            2'b10:   byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
    end

    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (i_size)
            2'b00:   load_val = i_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = i_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = rd_word;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rd_data_d = rd_data_q;
        mis_d     = 1'b0;
        aerr_d    = 1'b0;
        case (state_q)
            INIT: begin
                if (!INIT_CLEAR) begin
                    state_d = READY;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_d = READY;
                    end
                end
            end
            default: begin
                if (access) begin
                    mis_d  = misaligned;
                    aerr_d = addr_err;
                    if (misaligned || addr_err) begin
                        rd_data_d = '0;
                    end else if (i_MemRead) begin
                        rd_data_d = load_val;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            clr_idx_q  <= '0;
            rd_data_q  <= '0;
            dbg_data_q <= '0;
            mis_q      <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rd_data_q  <= rd_data_d;
            dbg_data_q <= mem_q[i_dbg_address];
            mis_q      <= mis_d;
            aerr_q     <= aerr_d;
        end
    end

    assign o_ready      = (state_q == READY);
    assign o_read_data  = rd_data_q;
    assign o_dbg_data   = dbg_data_q;
    assign o_misaligned = mis_q;
    assign o_addr_error = aerr_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Self-checking bench: a byte-array model of the memory is compared with the DUT
// every cycle, plus literal expectations for the directed scenarios.
module tb_data_memory_bytelane;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   i_address;
    logic [31:0]   i_write_data;
    logic          i_MemRead;
    logic          i_MemWrite;
    logic [1:0]    i_size;
    logic          i_unsigned;
    logic [AW-1:0] i_dbg_address;
    logic [31:0]   o_read_data;
    logic [31:0]   o_dbg_data;
    logic          o_ready;
    logic          o_misaligned;
    logic          o_addr_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_bytelane #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_write_data(i_write_data),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
        .i_size(i_size), .i_unsigned(i_unsigned),
        .i_dbg_address(i_dbg_address),
        .o_read_data(o_read_data), .o_dbg_data(o_dbg_data),
        .o_ready(o_ready), .o_misaligned(o_misaligned), .o_addr_error(o_addr_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the array is plain words, accesses are byte loops.
    logic [31:0] m_mem [DEPTH];
    int          m_cnt   = 0;
    bit          m_ready = 1'b0;
    logic [31:0] e_rd    = '0;
    logic [31:0] e_dbg   = '0;
    bit          e_mis   = 1'b0;
    bit          e_aerr  = 1'b0;
    bit          e_dbg_valid = 1'b1;

    always @(posedge clk or negedge rst) begin
        logic [31:0] a, old, v;
        int          widx, ln, nb;
        bit          bad, mis;
        if (!rst) begin
            m_cnt = 0; m_ready = 1'b0; e_rd = '0; e_dbg = '0;
            e_mis = 1'b0; e_aerr = 1'b0; e_dbg_valid = 1'b1;
        end else if (!m_ready) begin
            e_mis = 1'b0; e_aerr = 1'b0; e_dbg_valid = 1'b0;
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end else begin
            a    = i_address;
            widx = int'((a / 4) % DEPTH);
            ln   = int'(a % 4);
            nb   = (i_size == 2'd0) ? 1 : (i_size == 2'd1) ? 2 : 4;
            bad  = a >= 32'(DEPTH * 4);
            mis  = (i_size == 2'd3) || (i_size == 2'd1 && a % 2 != 0) || (i_size == 2'd2 && a % 4 != 0);
            e_dbg = m_mem[i_dbg_address];
            e_dbg_valid = 1'b1;
            e_mis = 1'b0; e_aerr = 1'b0;
            if (i_MemRead || i_MemWrite) begin
                e_mis = mis; e_aerr = bad;
                if (mis || bad) begin
                    e_rd = '0;
                end else begin
                    old = m_mem[widx];
                    if (i_MemRead) begin
                        v = '0;
                        for (int k = 0; k < nb; k++) v[8*k +: 8] = old[8*(ln+k) +: 8];
                        if (!i_unsigned && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                        e_rd = v;
                    end
                    if (i_MemWrite) begin
                        for (int k = 0; k < nb; k++) m_mem[widx][8*(ln+k) +: 8] = i_write_data[8*k +: 8];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ready", {31'b0, o_ready}, {31'b0, m_ready});
        check("read_data", o_read_data, e_rd);
        check("misaligned", {31'b0, o_misaligned}, {31'b0, e_mis});
        check("addr_error", {31'b0, o_addr_error}, {31'b0, e_aerr});
        if (e_dbg_valid) check("dbg_data", o_dbg_data, e_dbg);
    end

    // Drives one request, lets it be sampled, then returns to idle.
    task automatic acc(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #2;
        i_MemRead = rd; i_MemWrite = wr; i_size = sz; i_unsigned = un;
        i_address = addr; i_write_data = wd;
        @(posedge clk); #2;
        i_MemRead = 1'b0; i_MemWrite = 1'b0;
    endtask

    task automatic dbg_read(input logic [AW-1:0] addr, input logic [31:0] exp, input string name);
        @(posedge clk); #2;
        i_dbg_address = addr;
        @(posedge clk); #2;
        check(name, o_dbg_data, exp);
    endtask

    initial begin
        rst = 1'b1; i_address = '0; i_write_data = '0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
        i_size = 2'd0; i_unsigned = 1'b0; i_dbg_address = '0;
        #3 rst = 1'b0;
        #1 check("reset_ready", {31'b0, o_ready}, 32'd0);
        check("reset_rdata", o_read_data, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        repeat (DEPTH - 1) @(posedge clk);
        #2 check("init_ready_low", {31'b0, o_ready}, 32'd0);
        @(posedge clk); #2 check("init_ready_high", {31'b0, o_ready}, 32'd1);

        dbg_read(8'd0,   32'h0, "dbg_w0");
        dbg_read(8'd5,   32'h0, "dbg_w5");
        dbg_read(8'd255, 32'h0, "dbg_w255");

        acc(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB);
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_10", o_read_data, 32'hAB00_0000);
        acc(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check("lb_13", o_read_data, 32'hFFFF_FFAB);
        acc(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        check("lbu_13", o_read_data, 32'h0000_00AB);
        acc(1'b1, 1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
        check("lbu_12", o_read_data, 32'h0);

        acc(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'hCAFE_8001);
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        check("lw_20", o_read_data, 32'h8001_0000);
        acc(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        check("lh_22", o_read_data, 32'hFFFF_8001);
        acc(1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        check("lhu_22", o_read_data, 32'h0000_8001);

        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h06, 32'h1234_5678);
        check("sw_06_mis", {31'b0, o_misaligned}, 32'd1);
        @(posedge clk); #2 check("sw_06_mis_drop", {31'b0, o_misaligned}, 32'd0);
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
        check("lw_04_unchanged", o_read_data, 32'h0);

        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        check("lw_400_aerr", {31'b0, o_addr_error}, 32'd1);
        check("lw_400_rdata", o_read_data, 32'h0);
        @(posedge clk); #2 check("lw_400_aerr_drop", {31'b0, o_addr_error}, 32'd0);
        acc(1'b1, 1'b0, 2'd3, 1'b0, 32'h00, 32'h0);
        check("size11_mis", {31'b0, o_misaligned}, 32'd1);
        acc(1'b1, 1'b0, 2'd3, 1'b0, 32'h401, 32'h0);
        check("both_mis", {31'b0, o_misaligned}, 32'd1);
        check("both_aerr", {31'b0, o_addr_error}, 32'd1);

        i_dbg_address = 8'd3;
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h1111_1111);
        acc(1'b1, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h2222_2222);
        check("rbw_rdata", o_read_data, 32'h1111_1111);
        check("rbw_dbg", o_dbg_data, 32'h1111_1111);
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        check("after_rbw_rdata", o_read_data, 32'h2222_2222);
        check("after_rbw_dbg", o_dbg_data, 32'h2222_2222);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            i_MemWrite = 1'b1; i_MemRead = 1'b0; i_size = 2'd2;
            i_address = 32'h40 + 32'(4 * i); i_write_data = 32'h0101_0101 * 32'(i + 1);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            i_MemWrite = 1'b0; i_MemRead = 1'b1; i_address = 32'h40 + 32'(4 * i);
        end
        @(posedge clk); #2;
        i_MemRead = 1'b0;
        check("burst_last", o_read_data, 32'h0808_0808);

        rst = 1'b0;
        #1 check("rst_mid_ready", {31'b0, o_ready}, 32'd0);
        check("rst_mid_rdata", o_read_data, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (100) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst_init100_ready", {31'b0, o_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF);
        check("init_store_noflag", {31'b0, o_misaligned | o_addr_error}, 32'd0);
        repeat (DEPTH - 3) @(posedge clk);
        #2 check("reinit_ready_low", {31'b0, o_ready}, 32'd0);
        @(posedge clk); #2 check("reinit_ready_high", {31'b0, o_ready}, 32'd1);
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        check("init_store_dropped", o_read_data, 32'h0);

        @(posedge clk); #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_bytelane.md
# data_memory_bytelane

Parametrised MEM-stage data memory for the pipelined MIPS core, replacing the fixed 32-word RAM. Supports byte, halfword and word loads/stores with little-endian lane selection and sign/zero extension, flags misaligned and out-of-range accesses, and exposes a second read-only port for the debug unit. After reset, a sequencer clears the array one word per cycle and holds off accesses until done.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, ≥ 4.
- ADDR_WIDTH, 32: width of the byte address from EX/MEM.
- INIT_CLEAR, 1: 1 = zero the array after reset; 0 = skip clearing (contents undefined).
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_address  input  ADDR_WIDTH  byte address from the EX/MEM latch.
- i_write_data  input  32  store data; the value is taken from the low bits for byte/half stores.
- i_MemRead  input  1  load request.
- i_MemWrite  input  1  store request.
- i_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- i_unsigned  input  1  1 = zero-extend loads (lbu/lhu); 0 = sign-extend.
- i_dbg_address  input  log2(DEPTH)  word address for the debug port.
- o_read_data  output  32  registered load result.
- o_dbg_data  output  32  registered debug read result.
- o_ready  output  1  high when the array accepts accesses.
- o_misaligned  output  1  one-cycle error pulse.
- o_addr_error  output  1  one-cycle error pulse.

## Operation
- FSM states are INIT and READY. Reset forces INIT with clear index 0.
- INIT (INIT_CLEAR=1): write 0 to the word at the clear index, then increment. After writing word DEPTH-1, go to READY.
- INIT (INIT_CLEAR=0): go to READY on the first clock after reset release.
- o_ready = (state == READY), registered.
- Word index = i_address[log2(DEPTH)+1:2]. Lane = i_address[1:0]. Lane 0 is bits 7:0.
- Address error: any bit of i_address at or above bit log2(DEPTH)+2 is set.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠00; i_size=11 (reserved) is always misaligned.
- An access is valid when o_ready=1, no error, and i_MemRead or i_MemWrite is asserted.
- Valid store: only the addressed lanes are written, using a byte-enable mask.
  - Byte: i_write_data[7:0] goes to lane addr[1:0].
  - Half: i_write_data[15:0] goes to bits 15:0 (addr[1]=0) or bits 31:16 (addr[1]=1).
  - Word: all 32 bits are written.
- Valid load: the lane is extracted and sign/zero-extended per i_unsigned, then registered into o_read_data. Word loads ignore i_unsigned.
- Errored access: no write; o_read_data <= 0; the matching flag pulses. If both conditions hold, both flags pulse.
- No load (i_MemRead=0), or o_ready=0: o_read_data holds its value. Requests during INIT are dropped silently with no flags.
- Load and store asserted together: both are performed; the load returns the pre-write contents (read-before-write).
- Debug port: o_dbg_data <= ram[i_dbg_address] every cycle in both states, with read-before-write semantics.

## Timing
- Reset values: o_read_data=0, o_dbg_data=0, o_ready=0, o_misaligned=0, o_addr_error=0, state=INIT, clear index=0.
- INIT lasts exactly DEPTH cycles after reset release; o_ready rises on the following edge.
- Load latency is 1 cycle: the request is sampled at edge N and data is valid after edge N. There is no back-pressure.
- A store sampled at edge N is visible to a load sampled at edge N+1.
- Error flags assert on the edge that samples the access and are low on the next edge unless a new errored access arrives.
- Reset asserted at any point, including mid-INIT or mid-access: outputs clear immediately and the clear sequence restarts from index 0. No partial write completes after reset assertion.
- Back-to-back accesses are accepted every cycle.

## Test plan
- Reset/INIT with DEPTH=256: release rst → o_ready low for 256 cycles, then high. Debug reads of word 0, 5 and 255 return 0x00000000.
- Byte lanes: sb 0xAB at 0x13 → lw 0x10 = 0xAB000000. lb 0x13 = 0xFFFFFFAB. lbu 0x13 = 0x000000AB. Other bytes of word 4 stay 0.
- Halfwords: sh 0x8001 at 0x22 → lw 0x20 = 0x80010000. lh 0x22 = 0xFFFF8001. lhu 0x22 = 0x00008001.
- Errors:
  - sw 0x12345678 at 0x06 → o_misaligned one-cycle pulse; word 1 unchanged.
  - lw 0x400 (DEPTH=256) → o_addr_error pulse and o_read_data=0.
  - i_size=11 → o_misaligned pulse.
- Simultaneous access: word 3 = 0x11111111; issue sw 0x22222222 and lw at 0x0C in the same cycle → o_read_data = 0x11111111; next lw → 0x22222222. Debug port at word 3 shows the same sequence.
- Reset mid-INIT: assert rst at INIT cycle 100 → o_ready stays 0; after release it takes a full 256 cycles again. A store issued during INIT does not change the array.
